// File: rtl/camera_capture_sequencer.sv
// Single-frame capture sequencer for the camera frame buffer.
// Gates buffer writes for exactly one whole frame, counts captured words,
// then serves byte-granular read addresses for SPI readback.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | waiting for a capture request
// S_ARMED     | request seen, waiting for the next frame_valid rise
// S_CAPTURING | write gate open until frame_valid falls
// S_DONE      | frame captured, readback address stepping allowed
module camera_capture_sequencer #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WORDS  = 10000
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  capture_request_in,
    input  logic                  abort_in,
    input  logic                  frame_valid_in,
    input  logic                  pixel_write_enable_in,
    output logic                  buffer_write_enable_out,
    input  logic                  read_next_in,
    output logic [ADDR_WIDTH-1:0] buffer_read_address_out,
    output logic [1:0]            byte_select_out,
    output logic [15:0]           bytes_available_out,
    output logic                  capture_busy_out,
    output logic                  capture_done_out,
    output logic                  overflow_out
);

    // MAX_WORDS*4 fits in 16 bits, so 14 bits always hold the word count.
    localparam logic [13:0] MAX_W = 14'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMED     = 2'd1,
        S_CAPTURING = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        fv_q, fv_d;
    logic [13:0] words_written_q, words_written_d;
    logic [15:0] bytes_read_q, bytes_read_d;
    logic        overflow_q, overflow_d;

    logic        rise, fall;
    logic        room;
    logic [15:0] bytes_captured;

    assign rise           = frame_valid_in & ~fv_q;
    assign fall           = ~frame_valid_in & fv_q;
    assign room           = (words_written_q < MAX_W);
    assign bytes_captured = {words_written_q, 2'b00};

    // Next-state, counter updates and the zero-latency write gate.
    always_comb begin
        state_d                 = state_q;
        fv_d                    = frame_valid_in;
        words_written_d         = words_written_q;
        bytes_read_d            = bytes_read_q;
        overflow_d              = overflow_q;
        buffer_write_enable_out = 1'b0;

        if (abort_in) begin
            // Abort beats a simultaneous request or write; overflow is kept.
            state_d         = S_IDLE;
            words_written_d = '0;
            bytes_read_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (capture_request_in) begin
                        state_d         = S_ARMED;
                        words_written_d = '0;
                        bytes_read_d    = '0;
                        overflow_d      = 1'b0;
                    end
                end
                S_ARMED: begin
                    // Only a fresh rise starts capture, so a frame already
                    // in progress on arming is skipped entirely.
                    if (rise) state_d = S_CAPTURING;
                end
                S_CAPTURING: begin
                    if (pixel_write_enable_in) begin
                        if (room) begin
                            buffer_write_enable_out = 1'b1;
                            words_written_d         = words_written_q + 14'd1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (fall) state_d = S_DONE;
                end
                S_DONE: begin
                    if (capture_request_in) begin
                        state_d         = S_ARMED;
                        words_written_d = '0;
                        bytes_read_d    = '0;
                        overflow_d      = 1'b0;
                    end else if (read_next_in && (bytes_read_q < bytes_captured)) begin
                        bytes_read_d = bytes_read_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q         <= S_IDLE;
            fv_q            <= 1'b0;
            words_written_q <= '0;
            bytes_read_q    <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fv_q            <= fv_d;
            words_written_q <= words_written_d;
            bytes_read_q    <= bytes_read_d;
            overflow_q      <= overflow_d;
        end
    end

    assign buffer_read_address_out = bytes_read_q[ADDR_WIDTH+1:2];
    assign byte_select_out         = bytes_read_q[1:0];
    assign bytes_available_out     = (state_q == S_DONE) ? (bytes_captured - bytes_read_q) : 16'd0;
    assign capture_busy_out        = (state_q == S_ARMED) || (state_q == S_CAPTURING);
    assign capture_done_out        = (state_q == S_DONE);
    assign overflow_out            = overflow_q;

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// Directed plus randomized bench for camera_capture_sequencer. Two instances
// share stimulus: one at full capacity, one with an 8-word buffer.
module tb_camera_capture_sequencer;

    localparam int MAXA = 10000;
    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic rst;
    logic req, abort, fv, pwe, rn;

    logic        we_a, we_b;
    logic [13:0] addr_a, addr_b;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] avail_a, avail_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

    always #5 clk = ~clk;

    camera_capture_sequencer #(.ADDR_WIDTH(14), .MAX_WORDS(MAXA)) u_a (
        .clock_in(clk), .reset_in(rst),
        .capture_request_in(req), .abort_in(abort),
        .frame_valid_in(fv), .pixel_write_enable_in(pwe),
        .buffer_write_enable_out(we_a), .read_next_in(rn),
        .buffer_read_address_out(addr_a), .byte_select_out(sel_a),
        .bytes_available_out(avail_a), .capture_busy_out(busy_a),
        .capture_done_out(done_a), .overflow_out(ovf_a)
    );

    camera_capture_sequencer #(.ADDR_WIDTH(14), .MAX_WORDS(MAXB)) u_b (
        .clock_in(clk), .reset_in(rst),
        .capture_request_in(req), .abort_in(abort),
        .frame_valid_in(fv), .pixel_write_enable_in(pwe),
        .buffer_write_enable_out(we_b), .read_next_in(rn),
        .buffer_read_address_out(addr_b), .byte_select_out(sel_b),
        .bytes_available_out(avail_b), .capture_busy_out(busy_b),
        .capture_done_out(done_b), .overflow_out(ovf_b)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference model: a phase letter per instance plus plain counts.
    // 'I' idle, 'A' armed, 'C' capturing, 'D' done.
    byte mode  [2];
    int  words [2];
    int  rd    [2];
    bit  movf  [2];
    int  maxw  [2];
    bit  mfv;
    int  wcnt  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = "I"; words[i] = 0; rd[i] = 0; movf[i] = 1'b0;
        end
        mfv = 1'b0;
    endtask

    task automatic chk_dut(input int i, input string p, input logic we, input logic [13:0] addr,
                           input logic [1:0] sel, input logic [15:0] avail,
                           input logic busy, input logic done, input logic ovf);
        bit exp_we;
        int exp_av;
        exp_we = (mode[i] == "C") && pwe && !abort && (words[i] < maxw[i]);
        exp_av = (mode[i] == "D") ? (words[i] * 4 - rd[i]) : 0;
        chk({p, "_we"},    32'(we),    32'(exp_we));
        chk({p, "_addr"},  32'(addr),  32'(rd[i] / 4));
        chk({p, "_sel"},   32'(sel),   32'(rd[i] % 4));
        chk({p, "_avail"}, 32'(avail), 32'(exp_av));
        chk({p, "_busy"},  32'(busy),  32'((mode[i] == "A") || (mode[i] == "C")));
        chk({p, "_done"},  32'(done),  32'(mode[i] == "D"));
        chk({p, "_ovf"},   32'(ovf),   32'(movf[i]));
    endtask

    task automatic model_step();
        bit rise_m, fall_m;
        rise_m = fv && !mfv;
        fall_m = !fv && mfv;
        for (int i = 0; i < 2; i++) begin
            if (abort) begin
                mode[i] = "I"; words[i] = 0; rd[i] = 0;
            end else if ((mode[i] == "I" || mode[i] == "D") && req) begin
                mode[i] = "A"; words[i] = 0; rd[i] = 0; movf[i] = 1'b0;
            end else if (mode[i] == "A") begin
                if (rise_m) mode[i] = "C";
            end else if (mode[i] == "C") begin
                if (pwe) begin
                    if (words[i] < maxw[i]) words[i]++;
                    else movf[i] = 1'b1;
                end
                if (fall_m) mode[i] = "D";
            end else if (mode[i] == "D") begin
                if (rn && rd[i] < words[i] * 4) rd[i]++;
            end
        end
        mfv = fv;
    endtask

    // One clock: check outputs against the model, advance across the edge.
    task automatic tick();
        #2;
        chk_dut(0, "a", we_a, addr_a, sel_a, avail_a, busy_a, done_a, ovf_a);
        chk_dut(1, "b", we_b, addr_b, sel_b, avail_b, busy_b, done_b, ovf_b);
        if (we_a === 1'b1) wcnt[0]++;
        if (we_b === 1'b1) wcnt[1]++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1; tick(); req = 1'b0;
    endtask

    // Whole frame of n words with random idle gaps; optionally the last
    // word lands in the same cycle as frame_valid falling.
    task automatic frame(input int n, input bit last_on_fall, input int gap_max);
        fv = 1'b1; pwe = 1'b0; tick();
        for (int k = 0; k < n; k++) begin
            pwe = 1'b0;
            repeat ($urandom_range(gap_max, 0)) tick();
            pwe = 1'b1;
            if (last_on_fall && k == n - 1) fv = 1'b0;
            tick();
        end
        pwe = 1'b0;
        if (!last_on_fall) begin
            fv = 1'b0; tick();
        end
        tick();
    endtask

    task automatic chk_all_zero(input string p, input logic we, input logic [13:0] addr,
                                input logic [1:0] sel, input logic [15:0] avail,
                                input logic busy, input logic done, input logic ovf);
        chk({p, "_rst_we"},    32'(we),    32'd0);
        chk({p, "_rst_addr"},  32'(addr),  32'd0);
        chk({p, "_rst_sel"},   32'(sel),   32'd0);
        chk({p, "_rst_avail"}, 32'(avail), 32'd0);
        chk({p, "_rst_busy"},  32'(busy),  32'd0);
        chk({p, "_rst_done"},  32'(done),  32'd0);
        chk({p, "_rst_ovf"},   32'(ovf),   32'd0);
    endtask

    initial begin
        maxw[0] = MAXA; maxw[1] = MAXB;
        wcnt[0] = 0;    wcnt[1] = 0;
        model_reset();
        rst = 1'b1; req = 1'b0; abort = 1'b0; fv = 1'b0; pwe = 1'b0; rn = 1'b0;
        #12;
        chk_all_zero("a", we_a, addr_a, sel_a, avail_a, busy_a, done_a, ovf_a);
        chk_all_zero("b", we_b, addr_b, sel_b, avail_b, busy_b, done_b, ovf_b);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // 1: ten-word frame
        pulse_req();
        tick();
        wcnt[0] = 0; wcnt[1] = 0;
        frame(10, 1'b0, 2);
        chk("t1_avail", 32'(avail_a), 32'd40);
        chk("t1_done",  32'(done_a),  32'd1);
        chk("t1_wr",    32'(wcnt[0]), 32'd10);

        // 3: 41 read pulses over 40 bytes
        for (int k = 0; k <= 40; k++) begin
            #2;
            chk("t3_addr", 32'(addr_a), 32'(k / 4));
            chk("t3_sel",  32'(sel_a),  32'(k % 4));
            rn = 1'b1; tick(); rn = 1'b0;
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();
        chk("t3_avail", 32'(avail_a), 32'd0);
        chk("t3_addr_end", 32'(addr_a), 32'd10);

        // 2: request while frame already high
        fv = 1'b1; tick(); tick();
        pulse_req();
        wcnt[0] = 0;
        for (int k = 0; k < 4; k++) begin
            pwe = 1'b1; tick(); pwe = 1'b0; tick();
        end
        fv = 1'b0; tick();
        chk("t2_partial_wr", 32'(wcnt[0]), 32'd0);
        frame(5, 1'b0, 2);
        chk("t2_wr",    32'(wcnt[0]), 32'd5);
        chk("t2_avail", 32'(avail_a), 32'd20);

        // 4: overflow on the 8-word instance
        pulse_req();
        tick();
        wcnt[0] = 0; wcnt[1] = 0;
        frame(12, 1'b0, 1);
        chk("t4_wr_b",    32'(wcnt[1]), 32'd8);
        chk("t4_ovf_b",   32'(ovf_b),   32'd1);
        chk("t4_avail_b", 32'(avail_b), 32'd32);
        chk("t4_avail_a", 32'(avail_a), 32'd48);
        pulse_req();
        chk("t4_ovf_clr", 32'(ovf_b),   32'd0);

        // 5: abort together with request and write mid-capture
        fv = 1'b1; tick();
        pwe = 1'b1; tick(); tick(); tick();
        abort = 1'b1; req = 1'b1;
        #1;
        chk("t5_gate_now", 32'(we_a), 32'd0);
        tick();
        abort = 1'b0; req = 1'b0;
        #1;
        chk("t5_busy",  32'(busy_a),  32'd0);
        chk("t5_gate",  32'(we_a),    32'd0);
        chk("t5_avail", 32'(avail_a), 32'd0);
        pwe = 1'b0; fv = 1'b0;
        tick();

        // 6: last write coincident with the frame falling edge
        pulse_req();
        tick();
        wcnt[0] = 0;
        frame(7, 1'b1, 1);
        chk("t6_wr",    32'(wcnt[0]), 32'd7);
        chk("t6_avail", 32'(avail_a), 32'd28);

        // 6: asynchronous reset mid-frame, observed before any clock edge
        pulse_req();
        fv = 1'b1; tick();
        pwe = 1'b1; tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("a", we_a, addr_a, sel_a, avail_a, busy_a, done_a, ovf_a);
        chk_all_zero("b", we_b, addr_b, sel_b, avail_b, busy_b, done_b, ovf_b);
        model_reset();
        pwe = 1'b0; fv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            req   = ($urandom_range(15, 0) == 0);
            abort = ($urandom_range(60, 0) == 0);
            if ($urandom_range(7, 0) == 0) fv = ~fv;
            pwe   = $urandom_range(1, 0);
            rn    = $urandom_range(1, 0);
            tick();
        end
        req = 1'b0; abort = 1'b0; fv = 1'b0; pwe = 1'b0; rn = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
